// File: rtl/param_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : param_seq_det
// Brief    : Runtime-programmable serial bit-pattern detector with saturating
//            match counter and overlapping/non-overlapping modes.
// Revision : 1.0 - initial release
// ============================================================================
module param_seq_det #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1001,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ip,
    input  logic               ip_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               seq_det,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_min_len = LEN_W'(2);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   hcnt_q,    hcnt_d;
    logic               seq_det_q, seq_det_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic               w_cfg_ok;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_hcnt_n;
    logic               w_match;

    always_comb begin
        w_cfg_ok = (cfg_len >= c_min_len) && (cfg_len <= c_max_len);

        // Only the low len bits of pattern and history take part in a compare.
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len_q));
        end

        w_hist_n = {hist_q[MAX_LEN-2:0], ip};
        w_hcnt_n = (hcnt_q == c_max_len) ? hcnt_q : hcnt_q + 1'b1;
        w_match  = (w_hcnt_n >= len_q) && (((w_hist_n ^ pattern_q) & w_mask) == '0);

        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        hcnt_d    = hcnt_q;
        seq_det_d = 1'b0;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;

        if (cfg_load && w_cfg_ok) begin
            // A legal load restarts the history; any bit offered alongside is dropped.
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            hcnt_d    = '0;
        end else begin
            cfg_err_d = cfg_load;
            if (ip_vld) begin
                hist_d = w_hist_n;
                hcnt_d = w_hcnt_n;
                if (w_match) begin
                    seq_det_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!overlap_q) begin
                        hcnt_d = '0;
                    end
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            hcnt_q    <= '0;
            seq_det_q <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            hcnt_q    <= hcnt_d;
            seq_det_q <= seq_det_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign seq_det   = seq_det_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_seq_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_seq_det
// Brief    : Scoreboard bench driving a default and a CNT_W=2 detector in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_seq_det;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ip = 1'b0;
    logic       ip_vld = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       seq_det_a, cfg_err_a, seq_det_b, cfg_err_b;
    logic [7:0] match_cnt_a;
    logic [1:0] match_cnt_b;

    always #5 clk = ~clk;

    param_seq_det dut_a (
        .clk(clk), .rst(rst), .ip(ip), .ip_vld(ip_vld), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .seq_det(seq_det_a), .match_cnt(match_cnt_a), .cfg_err(cfg_err_a)
    );

    param_seq_det #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .ip(ip), .ip_vld(ip_vld), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .seq_det(seq_det_b), .match_cnt(match_cnt_b), .cfg_err(cfg_err_b)
    );

    typedef struct packed {
        logic       det;
        logic       err;
        logic [7:0] c8;
        logic [1:0] c2;
        logic [7:0] tag;
    } exp_t;

    exp_t       sb_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] m_c8 = '0;
    logic [1:0] m_c2 = '0;
    logic [7:0] step_no = '0;

    task automatic check(input string name, input logic [7:0] tag, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s step %0d: got %0h, expected %0h", name, tag, act, req);
    endtask

    // Outputs settle after the edge that consumed the queued stimulus.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("seq_det_a",   e.tag, {7'b0, seq_det_a}, {7'b0, e.det});
            check("seq_det_b",   e.tag, {7'b0, seq_det_b}, {7'b0, e.det});
            check("cfg_err_a",   e.tag, {7'b0, cfg_err_a}, {7'b0, e.err});
            check("match_cnt_a", e.tag, match_cnt_a, e.c8);
            check("match_cnt_b", e.tag, {6'b0, match_cnt_b}, {6'b0, e.c2});
        end
    end

    task automatic step(input logic r, input logic i, input logic v, input logic ld,
                        input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic clr, input logic ed, input logic ee);
        exp_t e;
        @(negedge clk);
        rst = r; ip = i; ip_vld = v; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cnt_clr = clr;
        if (r || clr) begin
            m_c8 = '0;
            m_c2 = '0;
        end else if (ed) begin
            if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
            if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
        end
        step_no = step_no + 8'd1;
        e.det = ed; e.err = ee; e.c8 = m_c8; e.c2 = m_c2; e.tag = step_no;
        sb_q.push_back(e);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bit_in(input logic i, input logic ed);
        step(1'b0, i, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ed, 1'b0);
    endtask

    task automatic stall(input logic i);
        step(1'b0, i, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic v, input logic i, input logic ed, input logic ee);
        step(1'b0, i, v, 1'b1, pat, len, ovl, 1'b0, ed, ee);
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] dets, input int n);
        for (int k = n - 1; k >= 0; k--) bit_in(bits[k], dets[k]);
    endtask

    initial begin
        // Defaults: 0,1,0,0,1,0,1,0,0,1,1 -> detects after bits 5 and 10
        do_rst();
        stream(16'b0100_1010_011, 16'b0000_1000_010, 11);

        // Overlap: 1,0,0,1,0,0,1 -> detects after bits 4 and 7
        do_rst();
        stream(16'b100_1001, 16'b000_1001, 7);
        // Non-overlap reload; upper pattern bits must be ignored
        load(8'hF9, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stream(16'b100_1001, 16'b000_1000, 7);

        // 8-bit pattern with a stall: 1,0,1,1,0, stall x3, 1,1,1
        load(8'b1011_0111, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stream(16'b1_0110, 16'b0, 5);
        stall(1'b1); stall(1'b0); stall(1'b1);
        stream(16'b111, 16'b001, 3);

        // Illegal loads: bit still enters history, cfg_err pulses
        do_rst();
        load(8'hFF, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        stream(16'b001, 16'b001, 3);
        load(8'hFF, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        stream(16'b001, 16'b001, 3);

        // Six matches to saturate the 2-bit counter, then clear vs match
        do_rst();
        stream(16'b1001, 16'b0001, 4);
        for (int k = 0; k < 5; k++) stream(16'b001, 16'b001, 3);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        bit_in(1'b0, 1'b0);

        // Length-2 pattern: back-to-back pulses
        load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stream(16'b1111, 16'b0111, 4);

        // Reset mid-pattern discards the partial history
        do_rst();
        stream(16'b100, 16'b000, 3);
        do_rst();
        stream(16'b1001, 16'b0001, 4);

        @(negedge clk);
        ip_vld = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clk);
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_seq_det.md
Name: param_seq_det

Overview:
- Runtime-programmable serial bit-pattern detector; parametrised successor to the fixed 4-bit "1001" FSM detector.
- Pattern length is configurable up to MAX_LEN, pattern value is loadable, and overlapping or non-overlapping detection is selectable.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial bit stream feeding framing/sync logic; with defaults it behaves exactly like the 1001 overlapping Moore detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_cnt.
- DEF_PATTERN, 8'b0000_1001, reset pattern (MAX_LEN bits, right-aligned).
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 1, reset mode (1 = overlapping).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ip  input  1  serial data bit.
- ip_vld  input  1  ip is sampled only when high.
- cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit [len-1] is received first, bit [0] last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  input  1  clear match_cnt.
- seq_det  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (rst=1 at an edge):
  - pattern, len, overlap take DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
  - History register, hcnt, seq_det, match_cnt and cfg_err all go to 0.
  - rst overrides every other input, including mid-pattern.
- State:
  - hist[MAX_LEN-1:0] is a shift register; a new bit enters at [0].
  - hcnt holds the valid-bit count since the last clear, saturating at MAX_LEN.
- Accepted bit (ip_vld=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], ip}.
  - hcnt_n = min(hcnt+1, MAX_LEN).
  - match = (hcnt_n >= len) AND (hist_n[len-1:0] == pattern[len-1:0]).
- On match:
  - seq_det=1 in the next cycle only, giving a 1-cycle latency from the sampling edge, Moore style.
  - match_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - Non-overlapping mode: hcnt is cleared to 0, so no bit is reused.
  - Overlapping mode: hcnt is kept, so a pattern suffix can seed the next match.
- Flow control:
  - ip_vld=0: hist and hcnt hold, and seq_det=0 next cycle.
  - Back-to-back matches give seq_det high on consecutive cycles.
- cfg_load:
  - Legal when 2 <= cfg_len <= MAX_LEN. The new pattern, len and overlap take effect next cycle, and hist and hcnt are cleared.
  - If ip_vld is high in the same cycle, that bit is discarded.
  - match_cnt is not affected.
  - Illegal cfg_len: configuration is unchanged, history is unchanged, the bit is still processed normally, and cfg_err pulses high for 1 cycle.
- cnt_clr:
  - match_cnt is 0 next cycle.
  - If a match occurs in the same cycle, clear wins (result 0), but seq_det still pulses.
- Pattern bits above len-1 are ignored.

Test Plan:
- Defaults, ip_vld=1, ip stream 0,1,0,0,1,0,1,0,0,1,1 after reset: seq_det pulses exactly 1 cycle after the 5th bit and after the 10th bit; final match_cnt=2.
- Default pattern, overlapping mode, stream 1,0,0,1,0,0,1: matches after bit 4 and bit 7, match_cnt=2. Reload with cfg_overlap=0, same stream: one match after bit 4 only, match_cnt increments by 1.
- Load pattern 8'b1011_0111, len=8, then stream 1,0,1,1,0 with ip_vld=0 for 3 cycles, then 1,1,1: single seq_det pulse after the last bit; no pulse during the stall; hist is held.
- cfg_load with cfg_len=1, and separately with cfg_len=9: cfg_err pulses once each; the 1001 pattern keeps detecting.
- CNT_W=2, six matches: match_cnt reads 1,2,3,3,3,3. cnt_clr asserted in the same cycle as a match: match_cnt=0 and seq_det=1.
- rst asserted after input 1,0,0: the following bit 1 gives no detection; a full 1,0,0,1 is needed for a match.
